// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit and the controller
// that decodes md_op/start.
//   - 4-bit md_op operation codes (MD_NONE .. MD_MTLO)
//   - FSM state type (MD_IDLE, MD_RUN)
//   - helpers to classify operation codes
package mult_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // Operations that open a busy window.
  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_calc.sv
// md_calc: purely combinational 64-bit multiply / 32-bit divide datapath.
// Ports:
//   op      in  4   md_op code (only MULT/MULTU/DIV/DIVU produce results)
//   a       in  32  rs operand (multiplicand / dividend)
//   b       in  32  rt operand (multiplier / divisor)
//   res_hi  out 32  product[63:32] or remainder
//   res_lo  out 32  product[31:0]  or quotient
//   dz      out 1   divide op with b==0; caller must leave HI/LO untouched
module md_calc
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        dz
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes with a shared unsigned divider and the
  // signs restored afterwards. This makes 0x80000000 / -1 wrap to 0x80000000
  // naturally instead of relying on signed-overflow behaviour of '/'.
  assign w_a_neg = (op == MD_DIV) && a[31];
  assign w_b_neg = (op == MD_DIV) && b[31];
  assign w_a_mag = w_a_neg ? (~a + 32'd1) : a;
  assign w_b_mag = w_b_neg ? (~b + 32'd1) : b;
  assign w_q_mag = (w_b_mag == '0) ? '0 : (w_a_mag / w_b_mag);
  assign w_r_mag = (w_b_mag == '0) ? '0 : (w_a_mag % w_b_mag);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    dz     = 1'b0;
    case (op)
      MD_MULT: begin
        res_hi = w_prod_s[63:32];
        res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = w_prod_u[63:32];
        res_lo = w_prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        dz     = (b == '0);
        res_lo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        res_hi = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
        dz     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with HI/LO registers.
// A MULT/MULTU/DIV/DIVU start latches the result into shadow registers and
// holds busy for MULT_CYCLES / DIV_CYCLES cycles, then commits to HI/LO.
// Ports:
//   clk      in  1   rising-edge clock
//   reset    in  1   asynchronous, active-low; clears all state
//   start    in  1   E-stage holds a MULT/MULTU/DIV/DIVU this cycle
//   md_op    in  4   operation code (mult_div_unit_pkg)
//   rs_data  in  32  forwarded rs operand
//   rt_data  in  32  forwarded rt operand
//   busy     out 1   computation in flight
//   hi       out 32  architectural HI
//   lo       out 32  architectural LO
//   md_out   out 32  MFHI ? hi : MFLO ? lo : 0 (combinational)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_sh_hi;
  logic [31:0]      r_sh_lo;
  logic             r_dz;

  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_dz;
  logic             w_start_ok;

  md_calc u_calc (
    .op     (md_op),
    .a      (rs_data),
    .b      (rt_data),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .dz     (w_dz)
  );

  // Starts are only honoured from IDLE; a start during RUN (including the
  // commit cycle) is dropped.
  assign w_start_ok = start && (r_state == MD_IDLE) && is_md_start_op(md_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sh_hi <= '0;
      r_sh_lo <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_start_ok) begin
            r_state <= MD_RUN;
            r_cnt   <= is_md_div_op(md_op) ? DIV_N : MULT_N;
            r_sh_hi <= w_res_hi;
            r_sh_lo <= w_res_lo;
            r_dz    <= w_dz;
          end else if (!start) begin
            if (md_op == MD_MTHI) r_hi <= rs_data;
            if (md_op == MD_MTLO) r_lo <= rs_data;
          end
        end
        MD_RUN: begin
          if (r_cnt == CNT_1) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            if (!r_dz) begin
              r_hi <= r_sh_hi;
              r_lo <= r_sh_lo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_1;
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (r_state == MD_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    md_out = '0;
    if (md_op == MD_MFHI)      md_out = r_hi;
    else if (md_op == MD_MFLO) md_out = r_lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = MD_NONE;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  mult_div_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          viol = 0;
  int          run_len = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the committed HI/LO model.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t              e;
    longint            sp, sa, sb_, sq, sr;
    longint unsigned   up, ua, ub, uq, ur;
    e.hi = mhi; e.lo = mlo; e.len = MC; e.name = "op";
    case (op)
      MD_MULT: begin
        sa = longint'($signed(a)); sb_ = longint'($signed(b));
        sp = sa * sb_;
        e.hi = sp[63:32]; e.lo = sp[31:0]; e.name = "MULT";
      end
      MD_MULTU: begin
        ua = longint'(a); ub = longint'(b);
        up = ua * ub;
        e.hi = up[63:32]; e.lo = up[31:0]; e.name = "MULTU";
      end
      MD_DIV: begin
        e.len = DC; e.name = "DIV";
        if (b != 0) begin
          sa = longint'($signed(a)); sb_ = longint'($signed(b));
          sq = sa / sb_; sr = sa % sb_;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end
      end
      MD_DIVU: begin
        e.len = DC; e.name = "DIVU";
        if (b != 0) begin
          ua = longint'(a); ub = longint'(b);
          uq = ua / ub; ur = ua % ub;
          e.lo = uq[31:0]; e.hi = ur[31:0];
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: measures each busy window and checks HI/LO when it closes.
  always @(negedge clk) begin
    exp_t e;
    if (reset && start && busy) viol++;
    if (!reset) begin
      run_len = 0;
    end else if (busy) begin
      run_len++;
    end else if (run_len > 0) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_commit: got busy window of %0d with empty scoreboard, required none", run_len);
      end else begin
        e = sb.pop_front();
        chk({e.name, " hi"}, hi, e.hi);
        chk({e.name, " lo"}, lo, e.lo);
        chk_int({e.name, " busy_len"}, run_len, e.len);
        mhi = e.hi;
        mlo = e.lo;
      end
      run_len = 0;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    if (is_md_start_op(op)) sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk_int("busy_timeout", n, 0);
    @(negedge clk); #1;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(posedge clk); #1;
    md_op = op; rs_data = v;
    @(posedge clk); #1;
    md_op = MD_NONE;
    if (op == MD_MTHI) mhi = v;
    if (op == MD_MTLO) mlo = v;
  endtask

  task automatic read_back(input string tag);
    md_op = MD_MFHI; #1;
    chk({tag, " mfhi"}, md_out, mhi);
    md_op = MD_MFLO; #1;
    chk({tag, " mflo"}, md_out, mlo);
    md_op = MD_NONE; #1;
    chk({tag, " md_out_none"}, md_out, 32'h0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    #20 reset = 1'b1;

    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);  wait_idle(); read_back("mult");
    issue(MD_MULTU, 32'hFFFFFFFE, 32'd3); wait_idle(); read_back("multu");
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);   wait_idle(); read_back("div");
    issue(MD_DIVU, 32'd7, 32'd2);         wait_idle(); read_back("divu");

    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    read_back("mt");
    issue(MD_DIV, 32'h1234, 32'h0);       wait_idle(); read_back("divzero");
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF); wait_idle(); read_back("divovf");

    // MTHI during busy is ignored; MFHI during busy shows the old HI.
    issue(MD_MULT, 32'd1000, 32'hFFFFFF00);
    md_op = MD_MFHI; #1;
    chk("mfhi_during_busy", md_out, mhi);
    md_op = MD_MTHI; rs_data = 32'hABCD;
    @(posedge clk); #1;
    md_op = MD_NONE;
    wait_idle();
    read_back("mthi_busy");
    mt(MD_MTHI, 32'hABCD);
    chk("mthi_idle hi", hi, 32'hABCD);

    // Second start mid-busy: no restart, DIV window length unchanged.
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1; start = 1'b1; md_op = MD_MULT; rs_data = 32'd5; rt_data = 32'd5;
    @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
    wait_idle(); read_back("restart");

    // Start presented on the commit cycle is dropped.
    issue(MD_MULTU, 32'h10000, 32'h10000);
    repeat (MC - 1) @(posedge clk);
    #1; start = 1'b1; md_op = MD_MULT; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
    repeat (3) @(posedge clk);
    #1;
    chk("commit_start busy", {31'd0, busy}, 32'd0);
    read_back("commit_start");
    chk_int("protocol_violations", viol, 2);

    // Unknown op with start has no effect.
    issue(4'hF, 32'd1, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("unknown_op busy", {31'd0, busy}, 32'd0);
    read_back("unknown_op");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rop = MD_MULT;
        1: rop = MD_MULTU;
        2: rop = MD_DIV;
        default: rop = MD_DIVU;
      endcase
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 16);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb);
      wait_idle();
      read_back("rand");
    end

    // Asynchronous reset in the middle of a DIV window.
    issue(MD_DIV, 32'd12345, 32'd7);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    mhi = '0; mlo = '0;
    chk("async_reset busy", {31'd0, busy}, 32'd0);
    chk("async_reset hi", hi, 32'h0);
    chk("async_reset lo", lo, 32'h0);
    #20 reset = 1'b1;
    repeat (DC + 2) @(posedge clk);
    #1;
    chk("post_reset busy", {31'd0, busy}, 32'd0);
    chk("post_reset hi", hi, 32'h0);
    chk("post_reset lo", lo, 32'h0);
    chk_int("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500000");
    $fatal(1);
  end

endmodule
